// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared memory handshake types and arbiter constants
package dmem_arbiter_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_e;

  localparam int arb_timeout_default_gp = 255;
endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting one past the last winner
module rr_picker #(
  parameter int num_req_p = 4,
  localparam int idx_w = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] i_req,
  input  logic [idx_w-1:0]     i_last,
  output logic [num_req_p-1:0] o_onehot,
  output logic [idx_w-1:0]     o_idx,
  output logic                 o_any
);
  logic [idx_w-1:0] w_j;
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = '0;
    // scan farthest-first so the nearest requester after i_last overwrites last
    for (int k = num_req_p; k >= 1; k--) begin
      w_j = idx_w'((int'(i_last) + k) % num_req_p);
      if (i_req[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
        o_any         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one data memory port, one transaction in flight
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int num_req_p = 4,
  parameter int timeout_p = arb_timeout_default_gp
) (
  input  logic                        clk,
  input  logic                        reset,
  input  mem_in_s  [num_req_p-1:0]    req_i,
  input  logic [num_req_p-1:0][31:0]  req_addr_i,
  output mem_out_s [num_req_p-1:0]    req_o,
  output mem_in_s                     mem_o,
  output logic [31:0]                 mem_addr_o,
  input  mem_out_s                    mem_i,
  output logic [num_req_p-1:0]        grant_o,
  output logic                        timeout_o
);
  localparam int idx_w = $clog2(num_req_p);
  localparam int tmr_w = $clog2(timeout_p + 1);

  arb_state_e           r_state;
  logic [num_req_p-1:0] r_grant;
  logic [idx_w-1:0]     r_gidx;
  logic [idx_w-1:0]     r_last;
  logic [tmr_w-1:0]     r_timer;
  logic                 r_timeout;
  logic [num_req_p-1:0] w_valid;
  logic [num_req_p-1:0] w_win;
  logic [idx_w-1:0]     w_win_idx;
  logic                 w_any;
  mem_in_s              w_greq;
  logic                 w_done;

  for (genvar i = 0; i < num_req_p; i++) begin : g_vld
    assign w_valid[i] = req_i[i].valid;
  end

  rr_picker #(.num_req_p(num_req_p)) u_pick (
    .i_req   (w_valid),
    .i_last  (r_last),
    .o_onehot(w_win),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  assign w_greq    = req_i[r_gidx];
  assign w_done    = mem_i.valid & w_greq.yumi;
  assign grant_o   = (r_state == ARB_IDLE) ? '0 : r_grant;
  assign timeout_o = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_last    <= idx_w'(num_req_p - 1);
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= r_timeout | (r_timer == tmr_w'(timeout_p));
      if (r_state != ARB_IDLE && r_timer != tmr_w'(timeout_p)) r_timer <= r_timer + 1'b1;
      case (r_state)
        ARB_IDLE: if (w_any) begin
          r_state <= ARB_REQ;
          r_grant <= w_win;
          r_gidx  <= w_win_idx;
          r_timer <= '0;
        end
        // a withdrawn request aborts only if memory has not taken it this cycle
        ARB_REQ: if (mem_i.yumi) begin
          r_last  <= r_gidx;
          r_state <= w_done ? ARB_IDLE : ARB_RESP;
        end else if (!w_greq.valid) r_state <= ARB_IDLE;
        ARB_RESP: if (w_done) r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_o      = '0;
    mem_addr_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_o[i].read_data = mem_i.read_data;
      req_o[i].valid     = 1'b0;
      req_o[i].yumi      = 1'b0;
    end
    if (r_state == ARB_REQ) begin
      mem_o               = w_greq;
      mem_addr_o          = req_addr_i[r_gidx];
      req_o[r_gidx].yumi  = mem_i.yumi;
    end
    if (r_state == ARB_RESP) mem_o.yumi = w_greq.yumi;
    if (r_state != ARB_IDLE) req_o[r_gidx].valid = mem_i.valid;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  localparam int N  = 4;
  localparam int TO = 8;

  logic                clk = 0;
  logic                reset = 0;
  mem_in_s  [N-1:0]    req_i = '0;
  logic [N-1:0][31:0]  req_addr_i = '0;
  mem_out_s [N-1:0]    req_o;
  mem_in_s             mem_o;
  logic [31:0]         mem_addr_o;
  mem_out_s            mem_i = '0;
  logic [N-1:0]        grant_o;
  logic                timeout_o;

  int n_chk = 0, n_pass = 0;

  logic [N-1:0] en = '0;
  int p_req = 0, p_myumi = 0, dmin = 0, dmax = 0, p_zl = 0, p_cyumi = 0, p_abort = 0;
  bit fix_pay = 0, fix_rd = 0, pend = 0;
  int cnt = 0;
  logic [31:0] rd_val = '0;

  int m_owner = -1, m_last = N - 1, m_cnt = 0;
  bit m_acc = 0, m_to = 0;
  logic [N-1:0] vld;

  dmem_arbiter #(.num_req_p(N), .timeout_p(TO)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_addr_i(req_addr_i), .req_o(req_o),
    .mem_o(mem_o), .mem_addr_o(mem_addr_o), .mem_i(mem_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < N; i++) vld[i] = req_i[i].valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  // transaction-level model: who owns the port, and whether memory has taken the request
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1; m_acc <= 0; m_last <= N - 1; m_cnt <= 0; m_to <= 0;
    end else begin
      if (m_cnt == TO) m_to <= 1;
      if (m_owner < 0) begin
        if (pick(vld, m_last) >= 0) begin
          m_owner <= pick(vld, m_last); m_acc <= 0; m_cnt <= 0;
        end
      end else begin
        m_cnt <= (m_cnt < TO) ? m_cnt + 1 : TO;
        if (!m_acc && mem_i.yumi) begin
          m_last <= m_owner;
          if (mem_i.valid && req_i[m_owner].yumi) m_owner <= -1;
          else m_acc <= 1;
        end else if (!m_acc && !req_i[m_owner].valid) m_owner <= -1;
        else if (m_acc && mem_i.valid && req_i[m_owner].yumi) m_owner <= -1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    mem_in_s em;
    mem_out_s er;
    logic [31:0] ea;
    logic [N-1:0] eg;
    em = '0; ea = '0; eg = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!m_acc) begin
        em = req_i[m_owner]; ea = req_addr_i[m_owner];
      end else em.yumi = req_i[m_owner].yumi;
    end
    check("grant", 64'(grant_o), 64'(eg));
    check("mem_o", 64'(mem_o), 64'(em));
    check("mem_addr", 64'(mem_addr_o), 64'(ea));
    check("timeout", 64'(timeout_o), 64'(m_to));
    for (int i = 0; i < N; i++) begin
      er.read_data = mem_i.read_data;
      er.valid = (i == m_owner) && mem_i.valid;
      er.yumi  = (i == m_owner) && !m_acc && mem_i.yumi;
      check("req_o", 64'(req_o[i]), 64'(er));
    end
  end

  task automatic cyc();
    logic [N-1:0] ack;
    logic mtake, rtake;
    @(negedge clk);
    for (int i = 0; i < N; i++) ack[i] = req_o[i].yumi;
    mtake = mem_i.yumi & mem_o.valid;
    rtake = mem_i.valid & mem_o.yumi;
    @(posedge clk); #1;
    if (mtake && !rtake) begin pend = 1; cnt = $urandom_range(dmax, dmin); end
    if (rtake) pend = 0;
    if (pend && cnt > 0) cnt--;
    for (int i = 0; i < N; i++) begin
      if (ack[i] || (req_i[i].valid && grant_o[i] && !pend && pct(p_abort))) req_i[i].valid = 0;
      else if (!req_i[i].valid && en[i] && pct(p_req)) begin
        req_i[i].valid = 1;
        req_i[i].wen = fix_pay | 1'($urandom);
        req_i[i].byte_not_word = fix_pay ? 1'b0 : 1'($urandom);
        req_i[i].write_data = fix_pay ? 32'hDEADBEEF : $urandom;
        req_addr_i[i] = fix_pay ? 32'h10 : $urandom;
      end
      req_i[i].yumi = pct(p_cyumi);
    end
    mem_i.valid = pend && cnt == 0;
    mem_i.read_data = fix_rd ? rd_val : $urandom;
    mem_i.yumi = 0;
    #1;
    if (mem_o.valid && !pend && pct(p_myumi)) begin
      mem_i.yumi = 1;
      if (pct(p_zl)) mem_i.valid = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 0; pend = 0; cnt = 0; en = '0;
    req_i = '0; req_addr_i = '0; mem_i = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1;
  endtask

  task automatic drain();
    en = '0; p_myumi = 100; p_cyumi = 100; p_abort = 0; p_zl = 0; dmin = 0; dmax = 1;
    repeat (20) cyc();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int order[8];
    int k;
    logic [N-1:0] prev;
    do_reset();
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    check("rst_mem_o", 64'(mem_o), 64'(0));

    // all four cores compete continuously
    en = '1; p_req = 100; p_myumi = 100; dmin = 0; dmax = 0; p_cyumi = 100;
    prev = '0; k = 0;
    for (int t = 0; t < 200 && k < 8; t++) begin
      cyc();
      if (grant_o != 0 && prev == 0) begin order[k] = oh2i(grant_o); k++; end
      prev = grant_o;
    end
    check("order_count", 64'(k), 64'(8));
    for (int j = 0; j < 8; j++) check("order", 64'(order[j]), 64'(j % 4));
    drain();

    // single store from core 2
    en = 4'b0100; fix_pay = 1; p_req = 100; p_myumi = 100; dmin = 2; dmax = 2; p_cyumi = 100;
    cyc();
    check("t1_arb_mem_valid", 64'(mem_o.valid), 64'(0));
    en = '0; fix_pay = 0;
    cyc();
    check("t1_grant", 64'(grant_o), 64'(4'b0100));
    check("t1_mem_valid", 64'(mem_o.valid), 64'(1));
    check("t1_wdata", 64'(mem_o.write_data), 64'(32'hDEADBEEF));
    check("t1_addr", 64'(mem_addr_o), 64'(32'h10));
    check("t1_core_yumi", 64'(req_o[2].yumi), 64'(1));
    cyc();
    check("t1_resp_mem_valid", 64'(mem_o.valid), 64'(0));
    check("t1_resp_addr", 64'(mem_addr_o), 64'(0));
    check("t1_resp_grant", 64'(grant_o), 64'(4'b0100));
    cyc();
    check("t1_core_valid", 64'(req_o[2].valid), 64'(1));
    cyc();
    check("t1_idle", 64'(grant_o), 64'(0));

    // zero-latency memory for core 1
    en = 4'b0010; p_zl = 100; fix_rd = 1; rd_val = 32'h12345678;
    cyc();
    en = '0;
    cyc();
    check("zl_grant", 64'(grant_o), 64'(4'b0010));
    check("zl_valid", 64'(req_o[1].valid), 64'(1));
    check("zl_yumi", 64'(req_o[1].yumi), 64'(1));
    check("zl_rdata", 64'(req_o[1].read_data), 64'(32'h12345678));
    cyc();
    check("zl_no_resp", 64'(grant_o), 64'(0));
    p_zl = 0; fix_rd = 0;

    // core 3 withdraws before memory accepts; last winner stays core 1
    en = 4'b1000; p_myumi = 0;
    cyc();
    en = '0;
    cyc();
    check("ab_grant", 64'(grant_o), 64'(4'b1000));
    en = 4'b0101; p_abort = 100;
    cyc();
    check("ab_mem_valid", 64'(mem_o.valid), 64'(0));
    check("ab_core_yumi", 64'(req_o[3].yumi), 64'(0));
    p_abort = 0; en = '0;
    cyc();
    check("ab_idle", 64'(grant_o), 64'(0));
    cyc();
    check("ab_next", 64'(grant_o), 64'(4'b0100));
    drain();

    // watchdog: memory accepts but never responds
    do_reset();
    en = 4'b0001; p_req = 100; p_myumi = 100; dmin = 1000; dmax = 1000; p_cyumi = 100;
    cyc();
    en = '0;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      if (j == 5) check("to_early", 64'(timeout_o), 64'(0));
      if (j == 14) check("to_set", 64'(timeout_o), 64'(1));
    end
    cnt = 0;
    k = 0;
    for (int t = 0; t < 10 && grant_o != 0; t++) cyc();
    check("to_complete", 64'(grant_o), 64'(0));
    check("to_sticky", 64'(timeout_o), 64'(1));

    // reset while waiting for a response
    en = 4'b0001;
    cyc();
    en = '0;
    cyc();
    cyc();
    check("rr_resp_grant", 64'(grant_o), 64'(4'b0001));
    reset = 0;
    #1;
    check("rr_grant", 64'(grant_o), 64'(0));
    check("rr_timeout", 64'(timeout_o), 64'(0));
    cnt = 0;
    #2 reset = 1;
    cyc();
    check("rr_stale_mem", 64'(mem_i.valid), 64'(1));
    for (int i = 0; i < N; i++) check("rr_stale_valid", 64'(req_o[i].valid), 64'(0));
    pend = 0;

    // randomized traffic
    do_reset();
    en = '1; p_req = 30; p_myumi = 50; dmin = 0; dmax = 4; p_zl = 20; p_cyumi = 60; p_abort = 3;
    repeat (3000) cyc();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
